if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch pipeline. It produces the `{inst, pc}` bus and valid that the decode stage consumes under the valid/allowin handshake. It drives the instruction SRAM-like port with one outstanding request at a time and redirects on taken branches reported by execute. An optional one-entry instruction buffer lets fetch keep issuing requests while decode stalls.

---
 rtl/if_stage_pkg.sv | 15 +
 rtl/fs_inst_buf.sv | 32 +++
 rtl/if_stage.sv | 168 ++++++++++++++++
 tb/tb_if_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, FSM encodings and reset PC for the fetch stage
package if_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 33;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fs_state_t;

endpackage

// File: rtl/fs_inst_buf.sv
// rtl/fs_inst_buf.sv - one-entry instruction buffer that absorbs a response while decode stalls
module fs_inst_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_inst,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // Flush beats push; a simultaneous push and pop simply replaces the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            inst  <= 32'd0;
            pc    <= 32'd0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            inst  <= push_inst;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage; FS_INST_BUF_EN adds a one-entry buffer behind fs
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                       inst_sram_req,
    output logic [31:0]                inst_sram_addr,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata
);

    fs_state_t   state;
    fs_state_t   state_next;
    logic [31:0] req_pc;
    logic        discard;
    logic        fs_valid;
    logic [31:0] fs_inst;
    logic [31:0] fs_pc;

    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_free;
    logic        issue;
    logic        resp;
    logic        resp_keep;
    logic        slot_free;

    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        buf_pop;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    assign fs_free   = !fs_valid || ds_allowin;
    assign issue     = inst_sram_req && inst_sram_addr_ok;
    assign resp      = (state == FS_WAIT) && inst_sram_data_ok;
    assign resp_keep = resp && !discard && !br_taken;

`ifdef FS_INST_BUF_EN
    logic buf_push;
    logic buf_valid_next;

    // New data lands in the buffer whenever fs cannot take it directly, including
    // the cycle the old buffer entry is moving into fs.
    assign buf_pop        = buf_valid && fs_free && !br_taken;
    assign buf_push       = resp_keep && (!fs_free || buf_valid);
    assign buf_valid_next = br_taken ? 1'b0 :
                            buf_push ? 1'b1 :
                            buf_pop  ? 1'b0 : buf_valid;
    assign slot_free      = !buf_valid_next;

    fs_inst_buf u_fs_inst_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (br_taken),
        .push      (buf_push),
        .push_inst (inst_sram_rdata),
        .push_pc   (req_pc),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );
`else
    assign buf_valid = 1'b0;
    assign buf_inst  = 32'd0;
    assign buf_pc    = 32'd0;
    assign buf_pop   = 1'b0;
    assign slot_free = fs_free;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FS_IDLE: begin
                if (slot_free) begin
                    state_next = FS_REQ;
                end
            end
            FS_REQ: begin
                if (issue) begin
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (resp) begin
                    if (discard || br_taken || slot_free) begin
                        state_next = FS_REQ;
                    end else begin
                        state_next = FS_IDLE;
                    end
                end
            end
            default: state_next = FS_IDLE;
        endcase
    end

    // Without the buffer the request is held back until fs is empty or draining,
    // so a returning word always has somewhere to go.
    always_comb begin
        inst_sram_req = 1'b0;
`ifdef FS_INST_BUF_EN
        inst_sram_req = (state == FS_REQ);
`else
        inst_sram_req = (state == FS_REQ) && fs_free;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc  <= RESET_PC;
            discard <= 1'b0;
        end else if (br_taken) begin
            req_pc  <= br_target;
            discard <= issue || ((state == FS_WAIT) && !inst_sram_data_ok);
        end else begin
            if (resp) begin
                discard <= 1'b0;
            end
            if (resp_keep) begin
                req_pc <= req_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_inst  <= 32'd0;
            fs_pc    <= 32'd0;
        end else if (br_taken) begin
            fs_valid <= 1'b0;
        end else if (buf_pop) begin
            fs_valid <= 1'b1;
            fs_inst  <= buf_inst;
            fs_pc    <= buf_pc;
        end else if (resp_keep && fs_free) begin
            fs_valid <= 1'b1;
            fs_inst  <= inst_sram_rdata;
            fs_pc    <= req_pc;
        end else if (ds_allowin) begin
            fs_valid <= 1'b0;
        end
    end

    assign fs_to_ds_valid = fs_valid;
    assign fs_to_ds_bus   = {fs_inst, fs_pc};
    assign inst_sram_addr = req_pc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage with a behavioural SRAM responder
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allowin = 1'b1;
    logic [32:0] br_bus = 33'd0;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = 32'd0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

`ifdef FS_INST_BUF_EN
    localparam int EXP_EXTRA = 1;
`else
    localparam int EXP_EXTRA = 0;
`endif

    int tests = 0;
    int fails = 0;

    // SRAM responder: the word at address A is ~A, data_ok follows accept by 1+extra_lat cycles.
    logic        aok_en = 1'b1;
    int          extra_lat = 0;
    int          acc_cnt = 0;
    logic        pend = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    always @(posedge clk) begin
        #3;
        inst_sram_data_ok = 1'b0;
        if (pend) begin
            if (lat_cnt == 0) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = ~pend_addr;
                pend              = 1'b0;
            end else begin
                lat_cnt = lat_cnt - 1;
            end
        end
        inst_sram_addr_ok = aok_en && inst_sram_req && !pend;
        if (inst_sram_addr_ok) begin
            pend      = 1'b1;
            pend_addr = inst_sram_addr;
            lat_cnt   = extra_lat;
            acc_cnt   = acc_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        allowin;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_inst(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, {63'd0, fs_to_ds_valid}, 64'd1);
        chk({name, "_bus"}, fs_to_ds_bus, {~pc, pc});
    endtask

    task automatic do_reset(input logic allowin);
        reset      = 1'b1;
        br_bus     = 33'd0;
        ds_allowin = allowin;
        aok_en     = 1'b1;
        extra_lat  = 0;
        repeat (4) tick();
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int n;
        n = 0;
        while (!fs_to_ds_valid && n < 20) begin
            tick();
            n++;
        end
        chk_inst(name, pc);
    endtask

    initial begin
        logic [63:0] got[4];
        int          acc0;
        int          n;

        vecs[0] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h1c00_0000};
        vecs[1] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'h1c00_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 32'h1c00_0000,  1'b1, 32'h1c00_0004};
        vecs[4] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'h1c00_0004,  1'b1, 32'h1c00_0008};
        vecs[6] = '{1'b1, 1'b0, 32'h0,          1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h1c00_0008,  1'b1, 32'h1c00_000c};

        // Sequential fetch from reset, row 0 is the reset state
        do_reset(1'b1);
        chk("reset_bus", fs_to_ds_bus, 64'd0);
        chk("reset_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c00_0000});
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            chk($sformatf("seq%0d_valid", i), {63'd0, fs_to_ds_valid}, {63'd0, vecs[i].exp_valid});
            chk($sformatf("seq%0d_req", i), {63'd0, inst_sram_req}, {63'd0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                chk($sformatf("seq%0d_addr", i), {32'd0, inst_sram_addr}, {32'd0, vecs[i].exp_addr});
            if (vecs[i].exp_valid)
                chk($sformatf("seq%0d_bus", i), fs_to_ds_bus, {~vecs[i].exp_pc, vecs[i].exp_pc});
            ds_allowin = vecs[i].allowin;
        end

        // Decode stalls for 5 cycles with inst0 in fs
        do_reset(1'b0);
        repeat (3) tick();
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            chk_inst($sformatf("stall%0d", i), 32'h1c00_0000);
            tick();
        end
        chk("stall_extra_req", 64'(acc_cnt - acc0), 64'(EXP_EXTRA));
        ds_allowin = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (fs_to_ds_valid && n < 4) begin
                got[n] = fs_to_ds_bus;
                n++;
            end
            tick();
        end
        chk("stall_count", 64'(n), 64'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("stall_order%0d", j), got[j],
                {~(32'h1c00_0000 + 32'(4 * j)), 32'h1c00_0000 + 32'(4 * j)});
        end

        // Branch in WAIT before data_ok: the returning word is dropped
        do_reset(1'b1);
        extra_lat = 1;
        tick();
        tick();
        br_bus = {1'b1, 32'h1c00_0100};
        tick();
        br_bus    = 33'd0;
        extra_lat = 0;
        chk("brwait_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("brwait_req", {63'd0, inst_sram_req}, 64'd0);
        tick();
        chk("brwait_req2", {63'd0, inst_sram_req}, 64'd1);
        chk("brwait_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c00_0100});
        tick();
        tick();
        chk_inst("brwait_inst", 32'h1c00_0100);

        // Branch while fs holds a stalled instruction
        do_reset(1'b0);
        repeat (3) tick();
        chk_inst("brhold_pre", 32'h1c00_0000);
        br_bus = {1'b1, 32'h1c00_0100};
        tick();
        br_bus = 33'd0;
        chk("brhold_drop", {63'd0, fs_to_ds_valid}, 64'd0);
        ds_allowin = 1'b1;
        wait_valid("brhold_inst", 32'h1c00_0100);

        // Branch in REQ while addr_ok is held low
        do_reset(1'b1);
        aok_en = 1'b0;
        tick();
        chk("brreq_req0", {63'd0, inst_sram_req}, 64'd1);
        br_bus = {1'b1, 32'h1c00_0200};
        for (int i = 0; i < 3; i++) begin
            tick();
            br_bus = 33'd0;
            chk($sformatf("brreq_req%0d", i + 1), {63'd0, inst_sram_req}, 64'd1);
            chk($sformatf("brreq_addr%0d", i + 1), {32'd0, inst_sram_addr}, {32'd0, 32'h1c00_0200});
        end
        aok_en = 1'b1;
        tick();
        tick();
        chk_inst("brreq_inst", 32'h1c00_0200);

        // Branch coincident with data_ok, target at the top of the address space
        do_reset(1'b1);
        tick();
        tick();
        br_bus = {1'b1, 32'hffff_fffc};
        tick();
        br_bus = 33'd0;
        chk("brdok_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("brdok_addr", {32'd0, inst_sram_addr}, {32'd0, 32'hffff_fffc});
        tick();
        tick();
        chk_inst("brdok_inst", 32'hffff_fffc);
        chk("wrap_addr", {32'd0, inst_sram_addr}, 64'd0);
        tick();
        tick();
        chk_inst("wrap_inst", 32'h0000_0000);

        // Reset while waiting: the stale data_ok must be ignored
        do_reset(1'b1);
        extra_lat = 1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        extra_lat = 0;
        chk("rstmid_req", {63'd0, inst_sram_req}, 64'd0);
        tick();
        chk("rstmid_valid", {63'd0, fs_to_ds_valid}, 64'd0);
        chk("rstmid_addr", {32'd0, inst_sram_addr}, {32'd0, 32'h1c00_0000});
        tick();
        tick();
        chk_inst("rstmid_inst", 32'h1c00_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
